// File: rtl/uart_mem_burst.sv
// UART-attached register memory: serial CMD/ADDR/DATA frames drive burst writes and
// back-to-back burst reads of a small register array, with framing-error and timeout recovery.
module uart_mem_burst #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int BAUD_PERIOD = 3,
  parameter int LEN_BITS    = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_l,
  input  logic                                    RX,
  output logic                                    TX,
  output logic                                    busy,
  output logic                                    frame_err,
  output logic [7:0]                              err_count,
  output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]   mem_debug
);
  localparam int FW    = ADDR_WIDTH;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int HALF  = BAUD_PERIOD/2;
  localparam int BW    = $clog2(BAUD_PERIOD+1);
  localparam int IW    = $clog2(FW+3);
  localparam int TW    = $clog2(TIMEOUT+1);

  generate
    if (DATA_WIDTH > ADDR_WIDTH || BAUD_PERIOD < 2 || LEN_BITS+1 > ADDR_WIDTH) begin : g_bad_param
      $fatal(1, "uart_mem_burst: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
  state_t state, state_n;

  // ---------------- receiver ----------------
  logic rx_m, rx_s, rx_q, rx_act, rx_vld, rx_ferr;
  logic [BW-1:0] rx_cnt;
  logic [IW-1:0] rx_idx;
  logic [FW-1:0] rx_sh, rx_data;
  logic rx_smp, rx_start;

  assign rx_start = !rx_act && rx_q && !rx_s;
  assign rx_smp   = rx_act && (rx_cnt == BW'(HALF));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_m <= 1'b1; rx_s <= 1'b1; rx_q <= 1'b1;
      rx_act <= 1'b0; rx_vld <= 1'b0; rx_ferr <= 1'b0;
      rx_cnt <= '0; rx_idx <= '0; rx_sh <= '0; rx_data <= '0;
    end else begin
      rx_m <= RX; rx_s <= rx_m; rx_q <= rx_s;
      rx_vld <= 1'b0; rx_ferr <= 1'b0;
      if (rx_start) begin
        rx_act <= 1'b1; rx_cnt <= BW'(1); rx_idx <= '0;
      end else if (rx_act) begin
        rx_cnt <= (rx_cnt == BW'(BAUD_PERIOD-1)) ? '0 : rx_cnt + 1'b1;
        if (rx_cnt == BW'(BAUD_PERIOD-1)) rx_idx <= rx_idx + 1'b1;
        if (rx_smp) begin
          if (rx_idx == '0) begin
            if (rx_s) rx_act <= 1'b0;             // glitch, not a real start bit
          end else if (rx_idx == IW'(FW+1)) begin
            rx_act <= 1'b0;
            if (rx_s) begin rx_vld <= 1'b1; rx_data <= rx_sh; end
            else rx_ferr <= 1'b1;
          end else begin
            rx_sh <= {rx_s, rx_sh[FW-1:1]};
          end
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic tx_busy, tx_ready;
  logic [BW-1:0] tx_bcnt;
  logic [IW-1:0] tx_left;
  logic [FW:0]   tx_sh;

  // Ready in the last clock of a stop bit so the next word starts with no gap.
  assign tx_ready = !tx_busy || (tx_bcnt == BW'(BAUD_PERIOD-1) && tx_left == '0);

  // ---------------- control ----------------
  logic op, rd_done, timeout;
  logic [LEN_BITS-1:0]   rem;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic do_cmd, do_addr, do_wr, do_ld, err_inc, ferr_set;

  assign timeout = (state == ADDR || state == WDATA) && !rx_act && !rx_start &&
                   (to_cnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    do_cmd = 1'b0; do_addr = 1'b0; do_wr = 1'b0; do_ld = 1'b0;
    err_inc = 1'b0; ferr_set = 1'b0;
    case (state)
      IDLE:  if (rx_vld) begin do_cmd = 1'b1; state_n = ADDR; end
      ADDR:  if (rx_vld) begin do_addr = 1'b1; state_n = op ? WDATA : RDATA; end
             else if (timeout) begin err_inc = 1'b1; state_n = IDLE; end
      WDATA: if (rx_vld) begin do_wr = 1'b1; if (rem == '0) state_n = IDLE; end
             else if (timeout) begin err_inc = 1'b1; state_n = IDLE; end
      RDATA: if (tx_ready) begin
               if (rd_done) state_n = IDLE;
               else         do_ld = 1'b1;
             end
      default: state_n = IDLE;
    endcase
    // Half-duplex: anything heard while replying is ignored, errors included.
    if (rx_ferr && state != RDATA) begin
      ferr_set = 1'b1; err_inc = 1'b1; state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      op <= 1'b0; rem <= '0; addr <= '0; rd_done <= 1'b0; to_cnt <= '0;
      frame_err <= 1'b0; err_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state != ADDR && state != WDATA || rx_act || rx_start) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (do_cmd)  begin op <= rx_data[0]; rem <= rx_data[LEN_BITS:1]; end
      if (do_addr) begin addr <= rx_data; rd_done <= 1'b0; end
      if (do_wr) begin
        mem[addr] <= rx_data[DATA_WIDTH-1:0];
        addr <= addr + 1'b1; rem <= rem - 1'b1;
      end
      if (do_ld) begin
        addr <= addr + 1'b1;
        if (rem == '0) rd_done <= 1'b1;
        else rem <= rem - 1'b1;
      end
      if (ferr_set) frame_err <= 1'b1;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      TX <= 1'b1; tx_busy <= 1'b0; tx_bcnt <= '0; tx_left <= '0; tx_sh <= '0;
    end else if (do_ld) begin
      TX <= 1'b0; tx_busy <= 1'b1; tx_bcnt <= '0; tx_left <= IW'(FW+1);
      tx_sh <= {1'b1, FW'(mem[addr])};
    end else if (tx_busy) begin
      if (tx_bcnt == BW'(BAUD_PERIOD-1)) begin
        tx_bcnt <= '0;
        if (tx_left == '0) begin
          tx_busy <= 1'b0; TX <= 1'b1;
        end else begin
          TX <= tx_sh[0]; tx_sh <= {1'b1, tx_sh[FW:1]}; tx_left <= tx_left - 1'b1;
        end
      end else begin
        tx_bcnt <= tx_bcnt + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
      assign mem_debug[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end
  endgenerate
endmodule

// File: tb/tb_uart_mem_burst.sv
// Directed bench for uart_mem_burst: table of burst write/read transactions plus
// hand sequences for framing error, timeout and reset in the middle of a read burst.
module tb_uart_mem_burst;
  localparam int BAUD = 3;

  logic clk = 1'b0, rst_l = 1'b0, RX = 1'b1;
  logic TX, busy, frame_err;
  logic [7:0]  err_count;
  logic [63:0] mem_debug;

  uart_mem_burst dut (
    .clk(clk), .rst_l(rst_l), .RX(RX), .TX(TX), .busy(busy),
    .frame_err(frame_err), .err_count(err_count), .mem_debug(mem_debug)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX monitor: one entry per received frame, {stop, data} and start cycle.
  logic [4:0] rx_q[$];
  int         st_q[$];
  initial begin
    logic [4:0] v;
    int st;
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        st = cyc;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin v[i] = TX; repeat (BAUD) @(negedge clk); end
        v[4] = TX;
        rx_q.push_back(v);
        st_q.push_back(st);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] v, input logic stop);
    logic [5:0] bits;
    bits = {stop, v, 1'b0};
    for (int i = 0; i < 6; i++) begin
      RX = bits[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [3:0] memw(input int a);
    return mem_debug[a*4 +: 4];
  endfunction

  typedef struct {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] data;  // write words, first word in bits [3:0]
    logic [15:0] exp;   // expected memory (write) or TX words (read)
  } vec_t;

  vec_t vec[6];

  initial begin
    int n, t;
    logic [3:0] a, w;
    logic [63:0] snap;

    vec[0] = '{4'h1, 4'h5, 16'h000A, 16'h000A};  // single write
    vec[1] = '{4'h7, 4'hE, 16'h4321, 16'h4321};  // 4-word write wrapping F->0
    vec[2] = '{4'h6, 4'hE, 16'h0000, 16'h4321};  // 4-word read across the wrap
    vec[3] = '{4'h3, 4'h8, 16'h00B7, 16'h00B7};  // 2-word write
    vec[4] = '{4'h2, 4'h8, 16'h0000, 16'h00B7};  // 2-word read
    vec[5] = '{4'h0, 4'h5, 16'h0000, 16'h000A};  // single read

    repeat (3) @(negedge clk);
    chk("reset_tx", TX, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_errcnt", err_count, 8'd0);
    chk("reset_mem", mem_debug, 64'd0);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      n = int'(vec[k].cmd[2:1]) + 1;
      rx_q.delete(); st_q.delete();
      send(vec[k].cmd, 1'b1);
      send(vec[k].addr, 1'b1);
      if (vec[k].cmd[0]) begin
        for (int i = 0; i < n; i++) begin w = vec[k].data[i*4 +: 4]; send(w, 1'b1); end
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          a = vec[k].addr + 4'(i);
          chk($sformatf("v%0d_mem%0h", k, a), memw(int'(a)), vec[k].exp[i*4 +: 4]);
        end
      end else begin
        t = 0;
        while ((rx_q.size() < n || busy) && t < 300) begin @(negedge clk); t++; end
        chk($sformatf("v%0d_rd_count", k), rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
          chk($sformatf("v%0d_rd%0d", k, i), rx_q[i], {1'b1, vec[k].exp[i*4 +: 4]});
          if (i > 0) chk($sformatf("v%0d_gap%0d", k, i), st_q[i] - st_q[i-1], 6*BAUD);
        end
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_tx_idle", k), TX, 1'b1);
      end
      chk($sformatf("v%0d_busy", k), busy, 1'b0);
      chk($sformatf("v%0d_errcnt", k), err_count, 8'd0);
    end

    // Framing error on the address frame.
    snap = mem_debug;
    send(4'h1, 1'b1);
    send(4'h3, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_flag", frame_err, 1'b1);
    chk("ferr_count", err_count, 8'd1);
    chk("ferr_busy", busy, 1'b0);
    chk("ferr_mem", mem_debug, snap);
    send(4'h1, 1'b1); send(4'h3, 1'b1); send(4'h9, 1'b1);
    repeat (6) @(negedge clk);
    chk("ferr_recover_mem3", memw(3), 4'h9);
    chk("ferr_recover_count", err_count, 8'd1);

    // Timeout after the first of two write words.
    send(4'h3, 1'b1); send(4'h4, 1'b1); send(4'h6, 1'b1);
    repeat (6) @(negedge clk);
    chk("to_mem4", memw(4), 4'h6);
    chk("to_busy_wait", busy, 1'b1);
    repeat (100) @(negedge clk);
    chk("to_busy", busy, 1'b0);
    chk("to_count", err_count, 8'd2);
    chk("to_mem5", memw(5), 4'hA);
    chk("to_ferr_kept", frame_err, 1'b1);

    // Reset during the second word of a read burst.
    rx_q.delete(); st_q.delete();
    send(4'h6, 1'b1); send(4'hE, 1'b1);
    t = 0;
    while (TX !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    chk("mid_first_start", TX, 1'b0);
    repeat (6*BAUD + 1) @(negedge clk);
    chk("mid_second_start", TX, 1'b0);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_tx", TX, 1'b1);
    chk("mid_rst_mem", mem_debug, 64'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_errcnt", err_count, 8'd0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (30) @(negedge clk);
    send(4'h1, 1'b1); send(4'h2, 1'b1); send(4'hC, 1'b1);
    repeat (6) @(negedge clk);
    chk("post_rst_mem2", memw(2), 4'hC);
    chk("post_rst_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
